// File: rtl/rv32i_load_pkg.sv
// rtl/rv32i_load_pkg.sv - shared load-type codes, FSM encoding and fault check for the load unit
package rv32i_load_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WB   = 2'd2,
      ERR  = 2'd3
   } load_state_t;

   // True when the load cannot be issued: reserved funct3 or an address the
   // access size cannot reach within one aligned word.
   function automatic logic load_fault(input logic [2:0] f3, input logic [1:0] off);
      logic fault;
      fault = 1'b0;
      case (f3)
         LB, LBU:  fault = 1'b0;
         LH, LHU:  fault = off[0];
         LW:       fault = (off != 2'b00);
         default:  fault = 1'b1;
      endcase
      return fault;
   endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - lane select and sign/zero extension of a loaded memory word
module load_extend
   import rv32i_load_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   output logic [31:0] result
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Pick the addressed byte and halfword, then extend according to the load type.
   always_comb begin
      byte_lane = rdata[7:0];
      half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
      result    = rdata;
      case (offset)
         2'd0:    byte_lane = rdata[7:0];
         2'd1:    byte_lane = rdata[15:8];
         2'd2:    byte_lane = rdata[23:16];
         default: byte_lane = rdata[31:24];
      endcase
      case (funct3)
         LB:      result = {{24{byte_lane[7]}}, byte_lane};
         LBU:     result = {24'h000000, byte_lane};
         LH:      result = {{16{half_lane[15]}}, half_lane};
         LHU:     result = {16'h0000, half_lane};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/load_unit.sv
// rtl/load_unit.sv - RV32I load unit: address, memory handshake, extension, writeback (optional LOAD_TIMEOUT_EN)
module load_unit
   import rv32i_load_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  funct3,
   input  logic [31:0] base,
   input  logic [11:0] imm,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] rd_data,
   output logic        rd_we,
   output logic        busy,
   output logic        err
);

   load_state_t state, state_next;
   logic [31:0] ea;
   logic [2:0]  lat_funct3;
   logic [1:0]  lat_off;
   logic [31:0] ext_result;
   logic        accept;

   assign ea     = base + {{20{imm[11]}}, imm};
   assign accept = (state == IDLE) && start && !load_fault(funct3, ea[1:0]);

   load_extend u_extend (
      .rdata  (mem_rdata),
      .funct3 (lat_funct3),
      .offset (lat_off),
      .result (ext_result)
   );

`ifdef LOAD_TIMEOUT_EN
   logic [7:0] tmo_count;
   logic       tmo_hit;

   assign tmo_hit = (tmo_count == 8'(TIMEOUT_CYCLES - 1));

   // Count REQ cycles that pass without an acknowledge; restart on every new request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tmo_count <= 8'd0;
      else if (state != REQ)
         tmo_count <= 8'd0;
      else if (!mem_ack)
         tmo_count <= tmo_count + 8'd1;
   end
`else
   logic tmo_hit;
   assign tmo_hit = 1'b0;
`endif

   // State register; reset forces IDLE so mem_req falls without waiting for a clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state selection and state-decoded outputs.
   always_comb begin
      state_next = state;
      mem_req    = 1'b0;
      rd_we      = 1'b0;
      err        = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start)
               state_next = load_fault(funct3, ea[1:0]) ? ERR : REQ;
         end
         REQ: begin
            mem_req = 1'b1;
            if (mem_ack)
               state_next = WB;
            else if (tmo_hit)
               state_next = ERR;
         end
         WB: begin
            rd_we      = 1'b1;
            state_next = IDLE;
         end
         default: begin
            err        = 1'b1;
            state_next = IDLE;
         end
      endcase
   end

   // Capture the request on acceptance and the extended result on acknowledge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_addr   <= 32'd0;
         lat_funct3 <= 3'd0;
         lat_off    <= 2'd0;
         rd_data    <= 32'd0;
      end else begin
         if (accept) begin
            mem_addr   <= {ea[31:2], 2'b00};
            lat_funct3 <= funct3;
            lat_off    <= ea[1:0];
         end
         if ((state == REQ) && mem_ack)
            rd_data <= ext_result;
      end
   end

endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - directed self-checking bench for load_unit
module tb_load_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] base = 32'd0;
   logic [11:0] imm = 12'd0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic [31:0] rd_data;
   logic        rd_we;
   logic        busy;
   logic        err;

   int checks = 0;
   int errors = 0;

   logic        o_req, o_err, o_both, o_we1, o_we2, o_busy2;
   logic [31:0] o_addr, o_data;

   always #5 clk = ~clk;

   load_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .funct3    (funct3),
      .base      (base),
      .imm       (imm),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .rd_data   (rd_data),
      .rd_we     (rd_we),
      .busy      (busy),
      .err       (err)
   );

   task automatic do_load(input logic [2:0] f3, input logic [31:0] b, input logic [11:0] im,
                          input int delay, input logic [31:0] rdat);
      @(negedge clk);
      start = 1'b1; funct3 = f3; base = b; imm = im; mem_ack = 1'b0;
      @(negedge clk);
      start = 1'b0;
      o_req = mem_req; o_addr = mem_addr; o_err = err; o_both = mem_req & rd_we;
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         o_req &= mem_req; o_err |= err; o_both |= mem_req & rd_we;
      end
      mem_ack = 1'b1; mem_rdata = rdat;
      @(negedge clk);
      mem_ack = 1'b0;
      o_we1 = rd_we; o_data = rd_data; o_err |= err; o_both |= mem_req & rd_we;
      @(negedge clk);
      o_we2 = rd_we; o_busy2 = busy; o_err |= err;
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++;
      if ({mem_req, rd_we, busy, err} !== 4'b0000 || mem_addr !== 32'd0 || rd_data !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs: req=%b we=%b busy=%b err=%b addr=%h data=%h, required all 0",
                  mem_req, rd_we, busy, err, mem_addr, rd_data);
      end
      reset = 1'b0;
   endtask

   task automatic test_lw;
      do_load(3'b010, 32'h100, 12'h000, 2, 32'hDEADBEEF);
      checks++;
      if (o_addr !== 32'h100 || o_req !== 1'b1) begin
         errors++; $display("FAIL lw_addr: addr=%h req=%b, required 00000100 1", o_addr, o_req);
      end
      checks++;
      if (o_data !== 32'hDEADBEEF || o_we1 !== 1'b1 || o_we2 !== 1'b0) begin
         errors++; $display("FAIL lw_data: data=%h we=%b%b, required deadbeef 10", o_data, o_we1, o_we2);
      end
      checks++;
      if (o_err !== 1'b0 || o_both !== 1'b0 || o_busy2 !== 1'b0) begin
         errors++; $display("FAIL lw_flags: err=%b req&we=%b busy=%b, required 0 0 0", o_err, o_both, o_busy2);
      end
   endtask

   task automatic test_byte;
      do_load(3'b000, 32'h100, 12'h003, 0, 32'h80123456);
      checks++;
      if (o_addr !== 32'h100 || o_data !== 32'hFFFFFF80 || o_we1 !== 1'b1) begin
         errors++; $display("FAIL lb: addr=%h data=%h we=%b, required 00000100 ffffff80 1", o_addr, o_data, o_we1);
      end
      do_load(3'b100, 32'h100, 12'h003, 1, 32'h80123456);
      checks++;
      if (o_data !== 32'h00000080 || o_we1 !== 1'b1 || o_err !== 1'b0) begin
         errors++; $display("FAIL lbu: data=%h we=%b err=%b, required 00000080 1 0", o_data, o_we1, o_err);
      end
      do_load(3'b000, 32'h100, 12'h001, 0, 32'h80123456);
      checks++;
      if (o_data !== 32'h00000034) begin
         errors++; $display("FAIL lb_lane1: data=%h, required 00000034", o_data);
      end
   endtask

   task automatic test_half;
      do_load(3'b101, 32'h200, 12'hFFE, 1, 32'hBEEF1234);
      checks++;
      if (o_addr !== 32'h1FC || o_data !== 32'h0000BEEF) begin
         errors++; $display("FAIL lhu: addr=%h data=%h, required 000001fc 0000beef", o_addr, o_data);
      end
      do_load(3'b001, 32'h200, 12'hFFE, 0, 32'hBEEF1234);
      checks++;
      if (o_addr !== 32'h1FC || o_data !== 32'hFFFFBEEF || o_we2 !== 1'b0) begin
         errors++; $display("FAIL lh: addr=%h data=%h we2=%b, required 000001fc ffffbeef 0", o_addr, o_data, o_we2);
      end
   endtask

   task automatic test_errors;
      logic [2:0] f3s [2];
      logic [31:0] bases [2];
      int n_err, n_req, n_we;
      f3s[0] = 3'b001; bases[0] = 32'h101;
      f3s[1] = 3'b011; bases[1] = 32'h100;
      for (int t = 0; t < 2; t++) begin
         n_err = 0; n_req = 0; n_we = 0;
         @(negedge clk);
         start = 1'b1; funct3 = f3s[t]; base = bases[t]; imm = 12'h000;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            n_err += int'(err); n_req += int'(mem_req); n_we += int'(rd_we);
         end
         checks++;
         if (n_err != 1 || n_req != 0 || n_we != 0) begin
            errors++;
            $display("FAIL err_case%0d: err_cycles=%0d req_cycles=%0d we_cycles=%0d, required 1 0 0",
                     t, n_err, n_req, n_we);
         end
      end
      checks++;
      if (rd_data !== 32'hFFFFBEEF || busy !== 1'b0) begin
         errors++; $display("FAIL err_hold: data=%h busy=%b, required ffffbeef 0", rd_data, busy);
      end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      start = 1'b1; funct3 = 3'b010; base = 32'h300; imm = 12'h000;
      @(negedge clk);
      start = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({mem_req, rd_we, busy, err} !== 4'b0000 || rd_data !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid: req=%b we=%b busy=%b err=%b data=%h, required 0 0 0 0 00000000",
                  mem_req, rd_we, busy, err, rd_data);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      start = 1'b1; funct3 = 3'b010; base = 32'h400; imm = 12'h004;
      mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h404 || rd_we !== 1'b0) begin
         errors++; $display("FAIL fast_req: req=%b addr=%h we=%b, required 1 00000404 0", mem_req, mem_addr, rd_we);
      end
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if (rd_we !== 1'b1 || rd_data !== 32'hCAFEF00D || mem_req !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL fast_wb: we=%b data=%h req=%b err=%b, required 1 cafef00d 0 0", rd_we, rd_data, mem_req, err);
      end
      @(negedge clk);
      checks++;
      if (rd_we !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL fast_idle: we=%b busy=%b, required 0 0", rd_we, busy);
      end
   endtask

   task automatic test_start_while_busy;
      int n_we;
      n_we = 0;
      @(negedge clk);
      start = 1'b1; funct3 = 3'b010; base = 32'h500; imm = 12'h000;
      @(negedge clk);
      base = 32'h600;
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 32'h11223344;
      @(negedge clk);
      mem_ack = 1'b0; start = 1'b0;
      n_we += int'(rd_we);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_we += int'(rd_we) + int'(mem_req);
      end
      checks++;
      if (mem_addr !== 32'h500 || n_we != 1) begin
         errors++; $display("FAIL busy_ignore: addr=%h activity=%0d, required 00000500 1", mem_addr, n_we);
      end
   endtask

`ifdef LOAD_TIMEOUT_EN
   task automatic test_timeout;
      int n_req, n_err, err_at;
      n_req = 0; n_err = 0; err_at = -1;
      @(negedge clk);
      start = 1'b1; funct3 = 3'b010; base = 32'h700; imm = 12'h000; mem_ack = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         start = 1'b0;
         n_req += int'(mem_req);
         if (err) begin n_err++; err_at = i; end
      end
      checks++;
      if (n_req != 4 || n_err != 1 || err_at != 4 || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout: req_cycles=%0d err_cycles=%0d err_at=%0d busy=%b, required 4 1 4 0",
                  n_req, n_err, err_at, busy);
      end
      do_load(3'b010, 32'h800, 12'h000, 3, 32'h0BADF00D);
      checks++;
      if (o_we1 !== 1'b1 || o_data !== 32'h0BADF00D || o_err !== 1'b0) begin
         errors++; $display("FAIL timeout_ack: we=%b data=%h err=%b, required 1 0badf00d 0", o_we1, o_data, o_err);
      end
   endtask
`else
   task automatic test_no_timeout;
      logic held;
      held = 1'b1;
      @(negedge clk);
      start = 1'b1; funct3 = 3'b010; base = 32'h700; imm = 12'h000; mem_ack = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!mem_req || err) held = 1'b0;
      end
      checks++;
      if (held !== 1'b1) begin
         errors++; $display("FAIL no_timeout: req_held=%b, required 1", held);
      end
      mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if (rd_we !== 1'b1 || rd_data !== 32'h0BADF00D) begin
         errors++; $display("FAIL late_ack: we=%b data=%h, required 1 0badf00d", rd_we, rd_data);
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      repeat (2) @(posedge clk);
      test_reset;
      test_lw;
      test_byte;
      test_half;
      test_errors;
      test_reset_mid;
      test_start_while_busy;
`ifdef LOAD_TIMEOUT_EN
      test_timeout;
`else
      test_no_timeout;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
